// File: rtl/run_time_counter.sv
// run_time_counter
//   Elapsed-time keeper for the seven-segment time display. Divides the
//   500 Hz scan clock down to a one-second tick, tracks an OFF/ON/WORKING
//   state from the power and work controls, and keeps two hh:mm:ss
//   counters: time since power-on and accumulated working time. A reminder
//   flag is raised once working hours reach a programmable limit.
//
//   Ports
//     clk_500Hz      in   scan clock
//     rst_n          in   asynchronous active-low reset
//     power_on       in   level, device powered
//     working        in   level, work session active (ignored when unpowered)
//     clear_working  in   pulse, zero the working counter
//     remind_hour    in   [5:0] reminder threshold in hours, 0 = disabled
//     power_on_*     out  [5:0] power-on hour/min/sec
//     working_*      out  [5:0] working hour/min/sec
//     tick_1hz       out  one-cycle pulse per second tick
//     state          out  [1:0] 00 OFF, 01 ON, 10 WORKING
//     remind_flag    out  working-hour reminder
//
//   State   | meaning
//   --------+---------------------------------------------
//   OFF     | unpowered, prescaler and power-on time at 0
//   ON      | powered, power-on time counting
//   WORKING | powered, power-on and working time counting
module run_time_counter #(
    parameter int TICK_DIV = 500,
    parameter int MAX_HOUR = 59
) (
    input  logic       clk_500Hz,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       working,
    input  logic       clear_working,
    input  logic [5:0] remind_hour,
    output logic [5:0] power_on_hour,
    output logic [5:0] power_on_min,
    output logic [5:0] power_on_sec,
    output logic [5:0] working_hour,
    output logic [5:0] working_min,
    output logic [5:0] working_sec,
    output logic       tick_1hz,
    output logic [1:0] state,
    output logic       remind_flag
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]    HOUR_MAX   = 6'(MAX_HOUR);
    localparam logic [5:0]    LAST_MS    = 6'd59;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_WORK = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          run_en;
    logic          work_en;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;

    // hh:mm:ss increment that sticks at MAX_HOUR:59:59 instead of wrapping.
    function automatic logic [17:0] hms_inc(input logic [5:0] h,
                                            input logic [5:0] m,
                                            input logic [5:0] s);
        logic [5:0] nh;
        logic [5:0] nm;
        logic [5:0] ns;
        nh = h;
        nm = m;
        ns = s;
        if (!(h == HOUR_MAX && m == LAST_MS && s == LAST_MS)) begin
            if (s == LAST_MS) begin
                ns = 6'd0;
                if (m == LAST_MS) begin
                    nm = 6'd0;
                    nh = h + 6'd1;
                end else begin
                    nm = m + 6'd1;
                end
            end else begin
                ns = s + 6'd1;
            end
        end
        return {nh, nm, ns};
    endfunction

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state. Losing power beats every other transition;
    // power and work rising together pass through ON for one cycle.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (power_on) state_d = ST_ON;
            end
            ST_ON: begin
                if (!power_on)   state_d = ST_OFF;
                else if (working) state_d = ST_WORK;
            end
            ST_WORK: begin
                if (!power_on)    state_d = ST_OFF;
                else if (!working) state_d = ST_ON;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (count enables from the pre-edge state)
    // ---------------------------------------------------------------
    always_comb begin
        run_en  = 1'b0;
        work_en = 1'b0;
        case (state_q)
            ST_ON:   run_en = 1'b1;
            ST_WORK: begin
                run_en  = 1'b1;
                work_en = 1'b1;
            end
            default: begin
                run_en  = 1'b0;
                work_en = 1'b0;
            end
        endcase
    end

    assign state = state_q;

    // ---------------------------------------------------------------
    // Prescaler. tick_1hz is registered from the next prescaler value so
    // it is high exactly while the prescaler sits at its last count.
    // ---------------------------------------------------------------
    always_comb begin
        presc_d = '0;
        if (run_en && state_d != ST_OFF) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
        tick_d = (state_d != ST_OFF) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            tick_1hz <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            tick_1hz <= tick_d;
        end
    end

    // ---------------------------------------------------------------
    // Time counters. Increments use the pre-edge state, so the second
    // that ends while leaving WORKING still lands in working time.
    // ---------------------------------------------------------------
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            power_on_hour <= 6'd0;
            power_on_min  <= 6'd0;
            power_on_sec  <= 6'd0;
        end else if (!run_en || state_d == ST_OFF) begin
            power_on_hour <= 6'd0;
            power_on_min  <= 6'd0;
            power_on_sec  <= 6'd0;
        end else if (tick_1hz) begin
            {power_on_hour, power_on_min, power_on_sec}
                <= hms_inc(power_on_hour, power_on_min, power_on_sec);
        end
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            working_hour <= 6'd0;
            working_min  <= 6'd0;
            working_sec  <= 6'd0;
        end else if (clear_working) begin
            working_hour <= 6'd0;
            working_min  <= 6'd0;
            working_sec  <= 6'd0;
        end else if (tick_1hz && work_en) begin
            {working_hour, working_min, working_sec}
                <= hms_inc(working_hour, working_min, working_sec);
        end
    end

    // Compares the registered hour, so the flag trails the counter by one
    // cycle, including when clear_working drops the hour to zero.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            remind_flag <= 1'b0;
        end else begin
            remind_flag <= (remind_hour != 6'd0) && (working_hour >= remind_hour);
        end
    end

endmodule

// File: tb/tb_run_time_counter.sv
module tb_run_time_counter;

    localparam int TD    = 4;
    localparam int MH    = 1;
    localparam int LIMIT = MH * 3600 + 3599;

    logic       clk_500Hz = 1'b0;
    logic       rst_n;
    logic       power_on;
    logic       working;
    logic       clear_working;
    logic [5:0] remind_hour;
    logic [5:0] power_on_hour, power_on_min, power_on_sec;
    logic [5:0] working_hour, working_min, working_sec;
    logic       tick_1hz;
    logic [1:0] state;
    logic       remind_flag;

    run_time_counter #(.TICK_DIV(TD), .MAX_HOUR(MH)) dut (
        .clk_500Hz    (clk_500Hz),
        .rst_n        (rst_n),
        .power_on     (power_on),
        .working      (working),
        .clear_working(clear_working),
        .remind_hour  (remind_hour),
        .power_on_hour(power_on_hour),
        .power_on_min (power_on_min),
        .power_on_sec (power_on_sec),
        .working_hour (working_hour),
        .working_min  (working_min),
        .working_sec  (working_sec),
        .tick_1hz     (tick_1hz),
        .state        (state),
        .remind_flag  (remind_flag)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    typedef struct {
        int    ph, pm, ps;
        int    wh, wm, ws;
        int    st;
        bit    tk;
        bit    fl;
        string tag;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    started = 0;
    string phase = "reset";

    // stimulus levels applied at each negedge
    bit       rst_v = 0, pw_v = 0, wk_v = 0, clr_v = 0;
    logic [5:0] rh_v = '0;

    // reference model: elapsed totals in seconds, cycles since power-up
    int m_st  = 0;
    int m_cyc = 0;
    int m_pon = 0;
    int m_wrk = 0;
    bit m_fl  = 0;
    int ticks_seen = 0;

    function automatic bit model_tick(input int st, input int cyc);
        return (st != 0) && ((cyc % TD) == TD - 1);
    endfunction

    task automatic model_step();
        exp_t e;
        int   nst;
        bit   tk;
        if (!rst_v) begin
            m_st = 0; m_cyc = 0; m_pon = 0; m_wrk = 0; m_fl = 0;
        end else begin
            tk = model_tick(m_st, m_cyc);
            if (m_st == 0)  nst = pw_v ? 1 : 0;
            else if (!pw_v) nst = 0;
            else            nst = wk_v ? 2 : 1;
            m_fl = (rh_v != 0) && ((m_wrk / 3600) >= int'(rh_v));
            if (m_st == 0 || nst == 0)   m_pon = 0;
            else if (tk && m_pon < LIMIT) m_pon++;
            if (clr_v)                                m_wrk = 0;
            else if (tk && m_st == 2 && m_wrk < LIMIT) m_wrk++;
            m_cyc = (m_st == 0 || nst == 0) ? 0 : m_cyc + 1;
            m_st  = nst;
            if (tk) ticks_seen++;
        end
        e.ph = m_pon / 3600; e.pm = (m_pon / 60) % 60; e.ps = m_pon % 60;
        e.wh = m_wrk / 3600; e.wm = (m_wrk / 60) % 60; e.ws = m_wrk % 60;
        e.st = m_st;
        e.tk = model_tick(m_st, m_cyc);
        e.fl = m_fl;
        e.tag = phase;
        sb_q.push_back(e);
        started = 1;
    endtask

    task automatic step();
        @(negedge clk_500Hz);
        rst_n         = rst_v;
        power_on      = pw_v;
        working       = wk_v;
        clear_working = clr_v;
        remind_hour   = rh_v;
        model_step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_ticks(input int n);
        int t0;
        int guard;
        t0 = ticks_seen;
        guard = 0;
        while ((ticks_seen - t0) < n && guard < (n + 4) * TD) begin
            step();
            guard++;
        end
    endtask

    task automatic pulse_clear();
        clr_v = 1;
        step();
        clr_v = 0;
    endtask

    // monitor: one comparison per clock against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_500Hz);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (power_on_hour != 6'(e.ph) || power_on_min != 6'(e.pm) ||
                    power_on_sec  != 6'(e.ps) || working_hour != 6'(e.wh) ||
                    working_min   != 6'(e.wm) || working_sec  != 6'(e.ws) ||
                    state != 2'(e.st) || tick_1hz != e.tk || remind_flag != e.fl) begin
                    bad++;
                    $display("FAIL %s t=%0t got pon=%0d:%0d:%0d wrk=%0d:%0d:%0d st=%0d tk=%0d fl=%0d exp pon=%0d:%0d:%0d wrk=%0d:%0d:%0d st=%0d tk=%0d fl=%0d",
                             e.tag, $time, power_on_hour, power_on_min, power_on_sec,
                             working_hour, working_min, working_sec, state, tick_1hz, remind_flag,
                             e.ph, e.pm, e.ps, e.wh, e.wm, e.ws, e.st, e.tk, e.fl);
                end
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL sb_empty t=%0t got no expectation exp one per cycle", $time);
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL timeout t=%0t got still running exp finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; power_on = 1'b0; working = 1'b0;
        clear_working = 1'b0; remind_hour = '0;

        // reset held, then power on for three seconds
        steps(3);
        rst_v = 1;
        phase = "power_on_3s";
        pw_v = 1;
        run_ticks(3);
        steps(2);

        // work 61 s, then idle 5 s
        phase = "work_61s";
        wk_v = 1;
        run_ticks(61);
        phase = "idle_5s";
        wk_v = 0;
        run_ticks(5);
        steps(2);

        // clear coincident with a tick
        phase = "clear_on_tick";
        pulse_clear();
        wk_v = 1;
        run_ticks(10);
        while (!model_tick(m_st, m_cyc)) step();
        pulse_clear();
        steps(3);

        // power lost mid-count while working
        phase = "power_drop";
        for (int g = 0; g < 4 * TD && !(m_st == 2 && (m_cyc % TD) == 1); g++) step();
        pw_v = 0;
        steps(3);
        phase = "repower";
        pw_v = 1;
        run_ticks(2);

        // asynchronous reset mid-count
        phase = "async_reset";
        for (int g = 0; g < 4 * TD && (m_cyc % TD) != 2; g++) step();
        #7;
        rst_n = 1'b0;
        rst_v = 0;
        #1;
        total++;
        if (power_on_hour != 0 || power_on_min != 0 || power_on_sec != 0 ||
            working_hour != 0 || working_min != 0 || working_sec != 0 ||
            state != 0 || tick_1hz != 0 || remind_flag != 0) begin
            bad++;
            $display("FAIL async_reset got pon=%0d:%0d:%0d wrk=%0d:%0d:%0d st=%0d tk=%0d fl=%0d exp all zero",
                     power_on_hour, power_on_min, power_on_sec,
                     working_hour, working_min, working_sec, state, tick_1hz, remind_flag);
        end
        steps(2);
        rst_v = 1;
        steps(2);

        // random control activity
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) pw_v = ~pw_v;
            if ($urandom_range(9) == 0)  wk_v = ~wk_v;
            clr_v = ($urandom_range(59) == 0);
            if ($urandom_range(199) == 0) rh_v = 6'($urandom_range(2));
            step();
        end
        clr_v = 0;

        // reminder at 1 h, then saturation at MAX_HOUR:59:59
        phase = "remind_sat";
        pw_v = 1; wk_v = 1; rh_v = 6'd1;
        pulse_clear();
        run_ticks(LIMIT + 6);
        steps(2);
        phase = "remind_clear";
        pulse_clear();
        steps(4);

        // reminder disabled
        phase = "remind_off";
        rh_v = 6'd0;
        run_ticks(3700);
        phase = "remind_reenable";
        rh_v = 6'd1;
        steps(3);

        @(posedge clk_500Hz);
        #2;
        started = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
